// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    DATA_PRI  = 1'b0,
    FETCH_PRI = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_D    = 2'd2
  } arb_owner_e;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data has priority, a starvation counter forces fetch through,
// and each read response is routed back to its owner one cycle after the grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_rdata_i
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_e state_p0, state_d;
  arb_owner_e owner_p1, owner_d;
  logic [3:0] starve_p0, starve_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0  <= DATA_PRI;
      starve_p0 <= 4'd0;
      owner_p1  <= OWNER_NONE;
    end else begin
      state_p0  <= state_d;
      starve_p0 <= starve_d;
      owner_p1  <= owner_d;
    end
  end

  // Issue stage: grant, memory drive and next priority state
  always_comb begin
    state_d        = state_p0;
    starve_d       = starve_p0;
    owner_d        = OWNER_NONE;
    if_gnt_o       = 1'b0;
    d_gnt_o        = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;

    // Grants are held off while reset is asserted so every output reads 0.
    if (rst) begin
      case (state_p0)
        FETCH_PRI: begin
          if (if_req_i)     if_gnt_o = 1'b1;
          else if (d_req_i) d_gnt_o  = 1'b1;
        end
        default: begin
          if (d_req_i)       d_gnt_o  = 1'b1;
          else if (if_req_i) if_gnt_o = 1'b1;
        end
      endcase
    end

    if (if_gnt_o) begin
      mem_addr_o    = if_addr_i;
      mem_read_en_o = 1'b1;
      owner_d       = OWNER_IF;
    end else if (d_gnt_o) begin
      mem_addr_o     = d_addr_i;
      mem_wdata_o    = d_wdata_i;
      mem_read_en_o  = !d_we_i;
      mem_write_en_o = d_we_i;
      owner_d        = d_we_i ? OWNER_NONE : OWNER_D;
    end

    if (if_gnt_o)
      starve_d = 4'd0;
    else if (if_req_i && (starve_p0 != STARVE_LIM))
      starve_d = starve_p0 + 4'd1;

    // Switching on the next count lets fetch win the cycle right after the limit is hit.
    case (state_p0)
      FETCH_PRI: if (if_gnt_o) state_d = DATA_PRI;
      default:   if (starve_d == STARVE_LIM) state_d = FETCH_PRI;
    endcase
  end

  // Response stage: route read data to the owner recorded at grant
  always_comb begin
    if_rvalid_o = (owner_p1 == OWNER_IF);
    d_rvalid_o  = (owner_p1 == OWNER_D);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing one unified instruction/data memory between the fetch stage and the load/store path. Sits between `fetch`/`decode` and `memory`, replacing the fixed fetch-only hookup. Issues at most one memory access per cycle and returns each read to its owner one cycle later. Data accesses win by default; a starvation counter guarantees fetch forward progress.

## Interface
Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win (range 1..15)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch read request, held with address until granted
- if_addr_i  in  AWIDTH  fetch address (the PC)
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  DWIDTH  fetch read data (instruction)
- d_req_i  in  1  data request, held with address/data/we until granted
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  AWIDTH  data address
- d_wdata_i  in  DWIDTH  store data
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  load data valid
- d_rdata_o  out  DWIDTH  load data
- mem_addr_o  out  AWIDTH  memory address
- mem_wdata_o  out  DWIDTH  memory write data
- mem_read_en_o  out  1  memory read strobe
- mem_write_en_o  out  1  memory write strobe
- mem_rdata_i  in  DWIDTH  memory read data, valid one cycle after mem_read_en_o

## Operation
- Priority FSM, two states: DATA_PRI (reset state), FETCH_PRI.
- DATA_PRI: if d_req_i is high, grant data. Otherwise, if if_req_i is high, grant fetch.
- FETCH_PRI: if if_req_i is high, grant fetch. Otherwise, if d_req_i is high, grant data.
- Starve counter, 4 bits:
  - increments, saturating at STARVE_MAX, each cycle if_req_i is high and if_gnt_o is low;
  - clears on any fetch grant.
- Transitions:
  - DATA_PRI to FETCH_PRI when the counter reaches STARVE_MAX (takes effect next cycle).
  - FETCH_PRI to DATA_PRI after the fetch grant.
- Grant is combinational from the current requests and state. if_gnt_o and d_gnt_o are never high together.
- On a grant, drive mem_addr_o and mem_wdata_o from the winner:
  - mem_read_en_o = grant and not a store;
  - mem_write_en_o = data grant and d_we_i.
- With no grant: mem strobes are 0, mem_addr_o is 0, mem_wdata_o is 0.
- Response tracking:
  - A registered owner tag (NONE/IF/D) is set on each read grant and set to NONE otherwise.
  - Next cycle, owner IF raises if_rvalid_o for one cycle; owner D raises d_rvalid_o for one cycle.
  - rdata outputs carry mem_rdata_i while their rvalid is high and are 0 otherwise.
- Stores produce no rvalid; a store is complete at its grant.
- Addresses are passed through unmodified. Alignment is not checked.

## Timing
- Reset (rst low, asynchronous): FSM = DATA_PRI, counter = 0, owner = NONE. All outputs read 0 while rst is low.
- Grant latency: 0 cycles (same cycle as the request when it wins).
- Read latency: rvalid exactly 1 cycle after the grant. Back-to-back grants give back-to-back rvalids (full throughput, one access per cycle).
- Simultaneous requests with counter < STARVE_MAX: data wins.
- Worst-case fetch wait: STARVE_MAX + 1 cycles from a held request.
- Request withdrawn before grant: allowed. No state change except the counter clearing? No: the counter holds its value.
- Reset asserted with a read outstanding: the response is dropped. No rvalid after release. The first post-reset cycle behaves as fresh.
- Counter saturates; no wrap-around.

## Structure
- Shared package `mem_arb_pkg`:
  - `arb_state_e` {DATA_PRI, FETCH_PRI};
  - `arb_owner_e` {OWNER_NONE, OWNER_IF, OWNER_D};
  - default STARVE_MAX constant.
- No sub-module. The FSM, counter and owner register fit in one module (~150 lines).

## Test plan
- Reset: hold rst low 3 cycles with both requests high → all outputs 0. After release, data is granted first.
- Solo fetch: if_req_i=1, if_addr_i=0x01000000, mem returns 0x00500093 → if_gnt_o same cycle, if_rvalid_o next cycle with if_rdata_o=0x00500093.
- Store then load: d store to 0x01000100 with 0xDEADBEEF, then load of the same address → mem_write_en_o=1 with no d_rvalid_o, then d_rvalid_o with 0xDEADBEEF one cycle after the load grant.
- Starvation, STARVE_MAX=4: both requests held continuously → data granted 4 cycles, fetch granted on the 5th, data on the 6th. Repeats 4:1.
- Back-to-back mixed reads (D, IF, D) → rvalids on consecutive cycles, each routed to the correct owner with the matching data.
- Reset mid-read: assert rst in the cycle after a fetch grant → no if_rvalid_o after deassertion; counter and FSM back to reset values.
